// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: DE-stage operand/producer info in, pipeline control out.
// The pipeline drives through master; the hazard unit sits on slave.
interface hazard_unit_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           rs1_de;
    logic [4:0]           rs2_de;
    logic                 use_rs1_de;
    logic                 use_rs2_de;
    logic [4:0]           rd_de;
    logic                 ru_write_de;
    logic                 load_de;
    logic                 branch_taken_ex;

    logic                 stall_pc;
    logic                 stall_if_de;
    logic                 flush_if_de;
    logic                 flush_de_ex;
    logic [1:0]           forward_a;
    logic [1:0]           forward_b;
    logic                 bypass_rs1_de;
    logic                 bypass_rs2_de;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    modport master (
        output rs1_de, rs2_de, use_rs1_de, use_rs2_de, rd_de, ru_write_de, load_de,
               branch_taken_ex,
        input  stall_pc, stall_if_de, flush_if_de, flush_de_ex, forward_a, forward_b,
               bypass_rs1_de, bypass_rs2_de, stall_count, flush_count
    );

    modport slave (
        input  rs1_de, rs2_de, use_rs1_de, use_rs2_de, rd_de, ru_write_de, load_de,
               branch_taken_ex,
        output stall_pc, stall_if_de, flush_if_de, flush_de_ex, forward_a, forward_b,
               bypass_rs1_de, bypass_rs2_de, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_unit.sv
// RV32I 5-stage hazard/forwarding controller: shadow scoreboard of EX/ME/WB, comb controls.
// Controls are combinational from scoreboard + DE inputs; scoreboard and counters update each edge.
module hazard_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } ex_slot_t;

    ex_slot_t             ex_q, ex_d;
    logic [4:0]           me_rd_q, wb_rd_q;
    logic                 me_wr_q, wb_wr_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic branch;
    logic load_use;
    logic stall;
    logic flush_de_ex;

    function automatic logic writes(input logic wr, input logic [4:0] rd, input logic [4:0] r);
        return wr && (rd == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_bit, input logic [4:0] r,
                                           input logic me_wr, input logic [4:0] me_rd,
                                           input logic wb_wr, input logic [4:0] wb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_bit && writes(me_wr, me_rd, r)) begin
            sel = 2'b01;
        end else if (use_bit && writes(wb_wr, wb_rd, r)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // Masking the branch input keeps every output quiet while reset is held.
    assign branch   = hz.branch_taken_ex & reset;
    assign load_use = ex_q.load && ex_q.wr && (ex_q.rd != 5'd0) &&
                      ((hz.use_rs1_de && (hz.rs1_de == ex_q.rd)) ||
                       (hz.use_rs2_de && (hz.rs2_de == ex_q.rd)));
    assign stall       = load_use && !branch;
    assign flush_de_ex = branch || load_use;

    assign hz.stall_pc      = stall;
    assign hz.stall_if_de   = stall;
    assign hz.flush_if_de   = branch;
    assign hz.flush_de_ex   = flush_de_ex;
    assign hz.forward_a     = fwd_sel(ex_q.use1, ex_q.rs1, me_wr_q, me_rd_q, wb_wr_q, wb_rd_q);
    assign hz.forward_b     = fwd_sel(ex_q.use2, ex_q.rs2, me_wr_q, me_rd_q, wb_wr_q, wb_rd_q);
    assign hz.bypass_rs1_de = hz.use_rs1_de && writes(wb_wr_q, wb_rd_q, hz.rs1_de);
    assign hz.bypass_rs2_de = hz.use_rs2_de && writes(wb_wr_q, wb_rd_q, hz.rs2_de);
    assign hz.stall_count   = stall_cnt_q;
    assign hz.flush_count   = flush_cnt_q;

    always_comb begin
        ex_d = '0;
        if (!flush_de_ex) begin
            ex_d.rs1  = hz.rs1_de;
            ex_d.rs2  = hz.rs2_de;
            ex_d.use1 = hz.use_rs1_de;
            ex_d.use2 = hz.use_rs2_de;
            ex_d.rd   = hz.rd_de;
            ex_d.wr   = hz.ru_write_de;
            ex_d.load = hz.load_de;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        flush_cnt_d = flush_cnt_q;
        if (branch && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q        <= '0;
            me_rd_q     <= 5'd0;
            me_wr_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_wr_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_rd_q     <= me_rd_q;
            wb_wr_q     <= me_wr_q;
            me_rd_q     <= ex_q.rd;
            me_wr_q     <= ex_q.wr;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with 2-bit counters so saturation is reachable quickly.
module tb_hazard_unit;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
    } de_t;

    typedef struct packed {
        logic [3:0] sf;     // {stall_pc, stall_if_de, flush_if_de, flush_de_ex}
        logic [1:0] fa;
        logic [1:0] fb;
        logic       b1;
        logic       b2;
        logic [1:0] sc;
        logic [1:0] fc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    hazard_unit_if #(.CNT_WIDTH(2)) hz ();

    hazard_unit #(.CNT_WIDTH(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic de_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic [4:0] rd, input logic wr,
                               input logic ld, input logic br);
        de_t d;
        d.rs1 = rs1; d.rs2 = rs2; d.u1 = u1; d.u2 = u2;
        d.rd = rd; d.wr = wr; d.ld = ld; d.br = br;
        return d;
    endfunction

    task automatic drive(input de_t d);
        hz.rs1_de          = d.rs1;
        hz.rs2_de          = d.rs2;
        hz.use_rs1_de      = d.u1;
        hz.use_rs2_de      = d.u2;
        hz.rd_de           = d.rd;
        hz.ru_write_de     = d.wr;
        hz.load_de         = d.ld;
        hz.branch_taken_ex = d.br;
    endtask

    task automatic chk(input string tag, input string f, input logic [3:0] obs,
                       input logic [3:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, f, obs, req);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        chk(tag, "stall_flush", {hz.stall_pc, hz.stall_if_de, hz.flush_if_de, hz.flush_de_ex}, e.sf);
        chk(tag, "forward_a", {2'b00, hz.forward_a}, {2'b00, e.fa});
        chk(tag, "forward_b", {2'b00, hz.forward_b}, {2'b00, e.fb});
        chk(tag, "bypass_rs1", {3'b000, hz.bypass_rs1_de}, {3'b000, e.b1});
        chk(tag, "bypass_rs2", {3'b000, hz.bypass_rs2_de}, {3'b000, e.b2});
        chk(tag, "stall_count", {2'b00, hz.stall_count}, {2'b00, e.sc});
        chk(tag, "flush_count", {2'b00, hz.flush_count}, {2'b00, e.fc});
    endtask

    // One pipeline cycle: inputs change just after the edge, outputs checked on the falling edge.
    task automatic step(input string tag, input de_t d, input logic [3:0] sf, input logic [1:0] fa,
                        input logic [1:0] fb, input logic b1, input logic b2,
                        input logic [1:0] sc, input logic [1:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        drive(d);
        e.sf = sf; e.fa = fa; e.fb = fb; e.b1 = b1; e.b2 = b2; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
        @(negedge clk);
        compare(tag);
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        e = '0;
        exp_q.push_back(e);
        #1;
        compare(tag);
    endtask

    localparam logic [3:0] STL = 4'b1101;
    localparam logic [3:0] FLS = 4'b0011;

    initial begin
        de_t         idle;
        logic [31:0] r;
        idle  = '0;
        reset = 1'b0;
        drive(idle);

        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            step("reset_random", de_t'(r[19:0]), 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0);
        end
        drive(idle);
        reset = 1'b1;
        check_now("reset_release");

        step("idle",        idle,                            4'h0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0);
        // ALU back-to-back on x5
        step("alu_add_x5",  mk(1, 2, 1, 1, 5, 1, 0, 0),      4'h0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0);
        step("alu_sub",     mk(5, 3, 1, 1, 6, 1, 0, 0),      4'h0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0);
        step("alu_fwd_me",  mk(4, 5, 1, 1, 8, 1, 0, 0),      4'h0, 2'd1, 2'd0, 0, 0, 2'd0, 2'd0);
        step("alu_fwd_wb",  idle,                            4'h0, 2'd0, 2'd2, 0, 0, 2'd0, 2'd0);
        step("bypass_rs1",  mk(6, 6, 1, 0, 0, 0, 0, 0),      4'h0, 2'd0, 2'd0, 1, 0, 2'd0, 2'd0);
        step("bypass_both", mk(8, 8, 1, 1, 0, 0, 0, 0),      4'h0, 2'd0, 2'd0, 1, 1, 2'd0, 2'd0);
        step("drain",       idle,                            4'h0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0);
        // Load-use on x7
        step("lw_x7",       mk(2, 0, 1, 0, 7, 1, 1, 0),      4'h0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0);
        step("lu_stall",    mk(3, 7, 1, 1, 11, 1, 0, 0),     STL,  2'd0, 2'd0, 0, 0, 2'd0, 2'd0);
        step("lu_release",  mk(3, 7, 1, 1, 11, 1, 0, 0),     4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0);
        step("lu_fwd_wb",   idle,                            4'h0, 2'd0, 2'd2, 0, 0, 2'd1, 2'd0);
        step("lu_drain",    idle,                            4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0);
        // x0 never matches
        step("x0_prod",     mk(0, 0, 0, 0, 0, 1, 1, 0),      4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0);
        step("x0_nostall",  mk(0, 0, 1, 1, 12, 1, 0, 0),     4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0);
        step("x0_nofwd",    idle,                            4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0);
        step("x0_nobyp",    mk(0, 0, 1, 0, 0, 0, 0, 0),      4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0);
        // Branch coincident with load-use
        step("lw_x13",      mk(1, 0, 1, 0, 13, 1, 1, 0),     4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0);
        step("br_over_lu",  mk(13, 0, 1, 0, 14, 1, 0, 1),    FLS,  2'd0, 2'd0, 0, 0, 2'd1, 2'd0);
        step("br_bubble",   idle,                            4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd1);
        // ME wins over WB for the same register
        step("prio_a",      mk(0, 0, 0, 0, 10, 1, 0, 0),     4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd1);
        step("prio_b",      mk(0, 0, 0, 0, 10, 1, 0, 0),     4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd1);
        step("prio_c",      mk(10, 10, 1, 1, 0, 0, 0, 0),    4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd1);
        step("prio_me",     idle,                            4'h0, 2'd1, 2'd1, 0, 0, 2'd1, 2'd1);
        // Branch on the cycle right after a stall
        step("lw_x15",      mk(0, 0, 0, 0, 15, 1, 1, 0),     4'h0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd1);
        step("stall2",      mk(0, 15, 0, 1, 16, 1, 0, 0),    STL,  2'd0, 2'd0, 0, 0, 2'd1, 2'd1);
        step("br_after_st", mk(0, 15, 0, 1, 16, 1, 0, 1),    FLS,  2'd0, 2'd0, 0, 0, 2'd2, 2'd1);
        step("after_br",    idle,                            4'h0, 2'd0, 2'd0, 0, 0, 2'd2, 2'd2);
        // Flush counter saturation at 3
        step("sat_1",       mk(0, 0, 0, 0, 0, 0, 0, 1),      FLS,  2'd0, 2'd0, 0, 0, 2'd2, 2'd2);
        step("sat_2",       mk(0, 0, 0, 0, 0, 0, 0, 1),      FLS,  2'd0, 2'd0, 0, 0, 2'd2, 2'd3);
        step("sat_3",       mk(0, 0, 0, 0, 0, 0, 0, 1),      FLS,  2'd0, 2'd0, 0, 0, 2'd2, 2'd3);
        step("sat_4",       mk(0, 0, 0, 0, 0, 0, 0, 1),      FLS,  2'd0, 2'd0, 0, 0, 2'd2, 2'd3);
        step("sat_5",       mk(0, 0, 0, 0, 0, 0, 0, 1),      FLS,  2'd0, 2'd0, 0, 0, 2'd2, 2'd3);
        step("sat_hold",    idle,                            4'h0, 2'd0, 2'd0, 0, 0, 2'd2, 2'd3);
        // Reset in the middle of a stall drops it
        step("lw_x17",      mk(0, 0, 0, 0, 17, 1, 1, 0),     4'h0, 2'd0, 2'd0, 0, 0, 2'd2, 2'd3);
        step("stall3",      mk(17, 0, 1, 0, 18, 1, 0, 0),    STL,  2'd0, 2'd0, 0, 0, 2'd2, 2'd3);
        reset = 1'b0;
        check_now("mid_stall_reset");
        step("reset_hold",  mk(17, 0, 1, 0, 18, 1, 0, 1),    4'h0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0);
        drive(idle);
        reset = 1'b1;
        check_now("reset_release2");
        step("post_reset",  idle,                            4'h0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
